matmul_seq: RTL
===============

Name: matmul_seq

Overview:
- Host-side sequencer for the `matmul` systolic core.
- Accepts one job as N operand beats on a valid/ready stream: beat k = {column k of A, row k of B}.
- Clears the core, issues the N CALC beats back-to-back, switches to NOP, and captures the N result rows the core emits.
- Returns the rows on a valid/ready result stream. Sits between the operand buffer/DMA and `matmul`; drives the core's op/a/b and consumes its c.

Parameters:
- N, 4, array dimension (lanes per beat, beats per job, result rows).
- W, 16, lane width in bits; lane i occupies bits [i*W +: W].
- CLR_CYCLES, 4, number of consecutive OP_CLEAR cycles issued per job.
- RD_LAT, 1, cycles from the first NOP cycle to the first valid row on mm_c.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  sequencer accepts operand beat.
- in_a  in  N*W  column k of A.
- in_b  in  N*W  row k of B.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts result row.
- out_c  out  N*W  result row r, r = 0..N-1.
- out_last  out  1  high with row N-1.
- busy  out  1  high from first accepted beat until the final row handshake.
- done  out  1  one-cycle pulse on the cycle after the final row handshake.
- mm_op  out  2  core opcode: 00 NOP, 01 CLEAR, 10 CALC.
- mm_a  out  N*W  core A input.
- mm_b  out  N*W  core B input.
- mm_c  in  N*W  core result output.

Behaviour:
- Reset (async, rst=1) applies immediately:
  - state FILL; all counters 0; mm_op=NOP; mm_a=mm_b=0.
  - in_ready=0, out_valid=0, out_c=0, out_last=0, busy=0, done=0.
  - Partial jobs and buffered rows are discarded. The core shares rst.
- All outputs are registered. Lane arithmetic wraps mod 2^W inside the core; the sequencer never modifies data.
- FILL:
  - On entry, mm_op=CLEAR for exactly CLR_CYCLES cycles, then NOP.
  - In parallel, in_ready=1 while beat count < N. Each handshake stores {in_a, in_b} at index = count and increments count.
  - Leave for ISSUE when count==N and the clear count is complete, whichever finishes last.
  - An in_valid beat arriving while count==N is not accepted (in_ready=0).
- ISSUE: N consecutive cycles with mm_op=CALC and mm_a/mm_b = buffered beat 0..N-1 in order, with no bubbles; the core cannot stall. Then go to WAIT.
- WAIT:
  - mm_op=NOP and mm_a=mm_b=0 from the first post-ISSUE cycle; mm_op stays NOP until the next job.
  - Count RD_LAT cycles, then go to CAPTURE.
- CAPTURE: sample mm_c on N consecutive cycles into row buffer 0..N-1, with no backpressure; row 0 is sampled RD_LAT cycles after the first NOP. Then go to SEND.
- SEND:
  - out_valid=1 with out_c = row r; r advances only on out_valid&out_ready.
  - out_c, out_valid and out_last stay stable while out_ready=0.
  - out_last = (r==N-1).
  - After the row N-1 handshake: out_valid=0, done pulses one cycle, busy drops, state returns to FILL and a new CLEAR burst starts.
- in_ready=0 in ISSUE, WAIT, CAPTURE and SEND; single-buffered, so the next job's operands are not accepted until SEND completes.
- busy rises the cycle after the first FILL handshake.
- Reset asserted in any state aborts the job; no done pulse. After release, the block restarts the FILL clear burst.

Decomposition:
- mm_pkg holds:
  - opcodes OP_NOP=2'b00, OP_CLEAR=2'b01, OP_CALC=2'b10.
  - defaults for N and W.
  - the sequencer state enum {FILL, ISSUE, WAIT, CAPTURE, SEND}.
- One sub-module, matmul_seq_buf: an N-entry register file with write index/enable and read index. Instantiate twice: operands at 2*N*W bits, results at N*W bits.
- The FSM and counters live in matmul_seq.

Test Plan:
- Reset: assert rst mid-SEND for 2 cycles -> out_valid=0, busy=0, mm_op=NOP immediately; after release, mm_op=CLEAR for 4 cycles; no done pulse.
- Basic job, with `matmul` attached:
  - Stimulus: in_a beats {13,9,5,1}, {14,10,6,2}, {15,11,7,3}, {16,12,8,4}; in_b beats {20,19,18,17}, {24,23,22,21}, {28,27,26,25}, {32,31,30,29} (lane 3..0).
  - Required: out_c rows {280,270,260,250}, {696,670,644,618}, {1112,1070,1028,986}, {1528,1470,1412,1354}; out_last on row 3; one done pulse.
- Back-to-back jobs: repeat the same operands immediately -> identical rows, which proves the CLEAR between jobs. mm_op sequence per job is CLEAR×4, CALC×4, then NOP.
- Input stalls: in_valid toggling 1,0,0,1,... -> mm_op still shows 4 contiguous CALC cycles after the 4th beat and the clear; same result rows.
- Output backpressure: out_ready low for 5 cycles on row 1 -> row 1 held stable; rows arrive in order; in_ready stays 0 until done.
- Extra beat: a 5th in_valid beat during FILL with count==4 -> in_ready=0, beat not consumed; it is accepted as beat 0 of the next job after done.

Source files
------------

// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared opcodes, default sizes and sequencer states for matmul_seq
package mm_pkg;

   localparam int N_DEF = 4;
   localparam int W_DEF = 16;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_CLEAR = 2'b01,
      OP_CALC  = 2'b10
   } op_e;

   typedef enum logic [2:0] {
      FILL,
      ISSUE,
      WAIT,
      CAPTURE,
      SEND
   } state_e;

endpackage

// File: rtl/matmul_seq_buf.sv
// rtl/matmul_seq_buf.sv - DEPTH-entry register file, one write port, one combinational read port
module matmul_seq_buf #(
   parameter int  DEPTH = 4,
   parameter int  DW    = 32,
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [IW-1:0] widx_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [IW-1:0] ridx_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[widx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/matmul_seq.sv
// rtl/matmul_seq.sv - job sequencer for the matmul systolic core
// Buffers N operand beats, clears and feeds the core, captures N result rows, streams them out.
module matmul_seq
   import mm_pkg::*;
#(
   parameter int N          = N_DEF,
   parameter int W          = W_DEF,
   parameter int CLR_CYCLES = 4,
   parameter int RD_LAT     = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N*W-1:0] in_a,
   input  logic [N*W-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N*W-1:0] out_c,
   output logic         out_last,
   output logic         busy,
   output logic         done,
   output logic [1:0]   mm_op,
   output logic [N*W-1:0] mm_a,
   output logic [N*W-1:0] mm_b,
   input  logic [N*W-1:0] mm_c
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(N + CLR_CYCLES + RD_LAT + 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
   logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [1:0]      mm_op_q, mm_op_d;
   logic [N*W-1:0]  mm_a_q, mm_a_d, mm_b_q, mm_b_d, out_c_q, out_c_d;
   logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic            out_last_q, out_last_d, busy_q, busy_d, done_q, done_d;

   logic            in_hs, out_hs;
   logic [IW-1:0]   op_ridx, res_ridx;
   logic [2*N*W-1:0] op_rdata;
   logic [N*W-1:0]  res_rdata;

   assign in_hs  = in_valid & in_ready_q;
   assign out_hs = out_valid_q & out_ready;

   assign op_ridx  = (state_q == FILL) ? '0 : idx_q[IW-1:0];
   // Look one row ahead so the next row is ready on the handshake edge.
   assign res_ridx = (state_q == SEND) ? IW'(idx_q + CW'(1)) : '0;

   matmul_seq_buf #(.DEPTH(N), .DW(2*N*W)) u_op_buf (
      .clk     (clk),
      .rst     (rst),
      .we_i    (in_hs),
      .widx_i  (beat_cnt_q[IW-1:0]),
      .wdata_i ({in_a, in_b}),
      .ridx_i  (op_ridx),
      .rdata_o (op_rdata)
   );

   matmul_seq_buf #(.DEPTH(N), .DW(N*W)) u_res_buf (
      .clk     (clk),
      .rst     (rst),
      .we_i    (state_q == CAPTURE),
      .widx_i  (idx_q[IW-1:0]),
      .wdata_i (mm_c),
      .ridx_i  (res_ridx),
      .rdata_o (res_rdata)
   );

   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      clr_cnt_d   = clr_cnt_q;
      idx_d       = idx_q;
      mm_op_d     = OP_NOP;
      mm_a_d      = '0;
      mm_b_d      = '0;
      in_ready_d  = 1'b0;
      out_valid_d = out_valid_q;
      out_c_d     = out_c_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         FILL: begin
            beat_cnt_d = beat_cnt_q + CW'(in_hs);
            if (in_hs) busy_d = 1'b1;
            if (beat_cnt_q == CW'(N) && clr_cnt_q == CW'(CLR_CYCLES)) begin
               state_d          = ISSUE;
               idx_d            = CW'(1);
               mm_op_d          = OP_CALC;
               {mm_a_d, mm_b_d} = op_rdata;
            end else begin
               if (clr_cnt_q < CW'(CLR_CYCLES)) begin
                  mm_op_d   = OP_CLEAR;
                  clr_cnt_d = clr_cnt_q + CW'(1);
               end
               in_ready_d = (beat_cnt_d < CW'(N));
            end
         end
         ISSUE: begin
            if (idx_q < CW'(N)) begin
               mm_op_d          = OP_CALC;
               {mm_a_d, mm_b_d} = op_rdata;
               idx_d            = idx_q + CW'(1);
            end else begin
               state_d = WAIT;
               idx_d   = '0;
            end
         end
         WAIT: begin
            if (idx_q + CW'(1) >= CW'(RD_LAT)) begin
               state_d = CAPTURE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + CW'(1);
            end
         end
         CAPTURE: begin
            idx_d = idx_q + CW'(1);
            if (idx_q == CW'(N-1)) begin
               state_d     = SEND;
               idx_d       = '0;
               out_valid_d = 1'b1;
               out_c_d     = res_rdata;
               out_last_d  = (N == 1);
            end
         end
         SEND: begin
            if (out_hs) begin
               if (idx_q == CW'(N-1)) begin
                  // Final row taken: restart the next job's clear burst on the same edge.
                  state_d     = FILL;
                  idx_d       = '0;
                  beat_cnt_d  = '0;
                  clr_cnt_d   = CW'(1);
                  mm_op_d     = OP_CLEAR;
                  in_ready_d  = 1'b1;
                  out_valid_d = 1'b0;
                  out_c_d     = '0;
                  out_last_d  = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  idx_d      = idx_q + CW'(1);
                  out_c_d    = res_rdata;
                  out_last_d = (idx_q == CW'(N-2));
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         beat_cnt_q  <= '0;
         clr_cnt_q   <= '0;
         idx_q       <= '0;
         mm_op_q     <= OP_NOP;
         mm_a_q      <= '0;
         mm_b_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_c_q     <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         clr_cnt_q   <= clr_cnt_d;
         idx_q       <= idx_d;
         mm_op_q     <= mm_op_d;
         mm_a_q      <= mm_a_d;
         mm_b_q      <= mm_b_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_c_q     <= out_c_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_c     = out_c_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign mm_op     = mm_op_q;
   assign mm_a      = mm_a_q;
   assign mm_b      = mm_b_q;

endmodule
